// File: rtl/expmul_row_ctrl.sv
// Per-query-row sequencer for expmul: tracks the running max, issues one expmul
// transaction per key and folds the results into the row accumulator.
// Optional EXPMUL_ACC_SAT_EN: saturating accumulator add plus sticky sat_flag_out.
module expmul_row_ctrl #(
  parameter int DIM     = 65,
  parameter int SCORE_W = 9,
  parameter int ELEM_W  = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_vld_in,
  output logic                    s_rdy_out,
  input  logic [SCORE_W-1:0]      s_in,
  input  logic [DIM*ELEM_W-1:0]   v_in,
  input  logic                    last_in,
  output logic                    em_vld_out,
  input  logic                    em_rdy_in,
  output logic [SCORE_W-1:0]      em_m_out,
  output logic [SCORE_W-1:0]      em_m_prev_out,
  output logic [SCORE_W-1:0]      em_s_out,
  output logic [DIM*ELEM_W-1:0]   em_o_prev_out,
  output logic [DIM*ELEM_W-1:0]   em_v_out,
  input  logic                    em_vld_in,
  output logic                    em_rdy_out,
  input  logic [DIM*ELEM_W-1:0]   em_exp_o_in,
  input  logic [DIM*ELEM_W-1:0]   em_exp_v_in,
  output logic                    o_vld_out,
  input  logic                    o_rdy_in,
  output logic [DIM*ELEM_W-1:0]   o_out
`ifdef EXPMUL_ACC_SAT_EN
  ,
  output logic                    sat_flag_out
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                state;
  logic                  first;
  logic                  last_lat;
  logic [SCORE_W-1:0]    m_run;
  logic [SCORE_W-1:0]    m_new;
  logic [SCORE_W-1:0]    m_prev;
  logic [SCORE_W-1:0]    s_lat;
  logic [DIM*ELEM_W-1:0] v_lat;
  logic [DIM*ELEM_W-1:0] acc;
  logic [DIM*ELEM_W-1:0] acc_sum;

`ifdef EXPMUL_ACC_SAT_EN
  localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};
  logic [ELEM_W:0] sum_ext;
  logic            clip_any;

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    acc_sum  = '0;
    sum_ext  = '0;
    clip_any = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      sum_ext = {em_exp_o_in[i*ELEM_W+ELEM_W-1], em_exp_o_in[i*ELEM_W +: ELEM_W]}
              + {em_exp_v_in[i*ELEM_W+ELEM_W-1], em_exp_v_in[i*ELEM_W +: ELEM_W]};
      if (sum_ext[ELEM_W] != sum_ext[ELEM_W-1]) begin
        clip_any = 1'b1;
        acc_sum[i*ELEM_W +: ELEM_W] = sum_ext[ELEM_W] ? SAT_MIN : SAT_MAX;
      end else begin
        acc_sum[i*ELEM_W +: ELEM_W] = sum_ext[ELEM_W-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < DIM; i++) begin
      acc_sum[i*ELEM_W +: ELEM_W] = em_exp_o_in[i*ELEM_W +: ELEM_W]
                                  + em_exp_v_in[i*ELEM_W +: ELEM_W];
    end
  end
`endif

  assign em_m_out      = m_new;
  assign em_m_prev_out = m_prev;
  assign em_s_out      = s_lat;
  assign em_v_out      = v_lat;
  assign em_o_prev_out = first ? '0 : acc;
  assign o_out         = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      first      <= 1'b1;
      last_lat   <= 1'b0;
      m_run      <= '0;
      m_new      <= '0;
      m_prev     <= '0;
      s_lat      <= '0;
      v_lat      <= '0;
      acc        <= '0;
      s_rdy_out  <= 1'b0;
      em_vld_out <= 1'b0;
      em_rdy_out <= 1'b0;
      o_vld_out  <= 1'b0;
`ifdef EXPMUL_ACC_SAT_EN
      sat_flag_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_rdy_out <= 1'b1;
          if (s_rdy_out && s_vld_in) begin
            s_lat    <= s_in;
            v_lat    <= v_in;
            last_lat <= last_in;
            // The first key of a row seeds the max; later keys keep it on ties.
            if (first) begin
              m_new  <= s_in;
              m_prev <= s_in;
            end else begin
              m_prev <= m_run;
              m_new  <= ($signed(s_in) > $signed(m_run)) ? s_in : m_run;
            end
            s_rdy_out  <= 1'b0;
            em_vld_out <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (em_rdy_in) begin
            em_vld_out <= 1'b0;
            em_rdy_out <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (em_vld_in) begin
            acc        <= acc_sum;
            m_run      <= m_new;
            first      <= 1'b0;
            em_rdy_out <= 1'b0;
`ifdef EXPMUL_ACC_SAT_EN
            if (clip_any) sat_flag_out <= 1'b1;
`endif
            if (last_lat) begin
              o_vld_out <= 1'b1;
              state     <= OUT;
            end else begin
              s_rdy_out <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        OUT: begin
          if (o_rdy_in) begin
            acc       <= '0;
            first     <= 1'b1;
            o_vld_out <= 1'b0;
            s_rdy_out <= 1'b1;
`ifdef EXPMUL_ACC_SAT_EN
            sat_flag_out <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expmul_row_ctrl.sv
// Directed bench for expmul_row_ctrl: the bench plays both the upstream fetch stage
// and a stub expmul, with hand-computed expectations for every transaction.
module tb_expmul_row_ctrl;
  localparam int DIM     = 65;
  localparam int SCORE_W = 9;
  localparam int ELEM_W  = 27;
  localparam int W       = DIM * ELEM_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_vld_in = 1'b0;
  logic               s_rdy_out;
  logic [SCORE_W-1:0] s_in = '0;
  logic [W-1:0]       v_in = '0;
  logic               last_in = 1'b0;
  logic               em_vld_out;
  logic               em_rdy_in = 1'b0;
  logic [SCORE_W-1:0] em_m_out;
  logic [SCORE_W-1:0] em_m_prev_out;
  logic [SCORE_W-1:0] em_s_out;
  logic [W-1:0]       em_o_prev_out;
  logic [W-1:0]       em_v_out;
  logic               em_vld_in = 1'b0;
  logic               em_rdy_out;
  logic [W-1:0]       em_exp_o_in = '0;
  logic [W-1:0]       em_exp_v_in = '0;
  logic               o_vld_out;
  logic               o_rdy_in = 1'b0;
  logic [W-1:0]       o_out;
`ifdef EXPMUL_ACC_SAT_EN
  logic               sat_flag_out;
`endif

  int checks = 0;
  int fails  = 0;

  expmul_row_ctrl #(.DIM(DIM), .SCORE_W(SCORE_W), .ELEM_W(ELEM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_vld_in(s_vld_in), .s_rdy_out(s_rdy_out), .s_in(s_in), .v_in(v_in), .last_in(last_in),
    .em_vld_out(em_vld_out), .em_rdy_in(em_rdy_in), .em_m_out(em_m_out),
    .em_m_prev_out(em_m_prev_out), .em_s_out(em_s_out), .em_o_prev_out(em_o_prev_out),
    .em_v_out(em_v_out), .em_vld_in(em_vld_in), .em_rdy_out(em_rdy_out),
    .em_exp_o_in(em_exp_o_in), .em_exp_v_in(em_exp_v_in),
    .o_vld_out(o_vld_out), .o_rdy_in(o_rdy_in), .o_out(o_out)
`ifdef EXPMUL_ACC_SAT_EN
    , .sat_flag_out(sat_flag_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkVec(input logic [ELEM_W-1:0] e0, input logic [ELEM_W-1:0] e1);
    logic [W-1:0] v;
    v = '0;
    v[0 +: ELEM_W]      = e0;
    v[ELEM_W +: ELEM_W] = e1;
    return v;
  endfunction

  function automatic logic [ELEM_W-1:0] elem1(input logic [W-1:0] v);
    return v[ELEM_W +: ELEM_W];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [SCORE_W-1:0] s, input logic last, input logic [W-1:0] v);
    int n;
    n = 0;
    s_in = s; v_in = v; last_in = last; s_vld_in = 1'b1;
    while (!s_rdy_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy_out) checkOutput("s_rdy_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_vld_in = 1'b0;
  endtask

  task automatic serveExpmul(input string tag, input logic [SCORE_W-1:0] m, input logic [SCORE_W-1:0] mp,
                             input logic [SCORE_W-1:0] s, input logic [ELEM_W-1:0] op1,
                             input logic [ELEM_W-1:0] v1, input logic [W-1:0] eo,
                             input logic [W-1:0] ev, input int stall);
    int n;
    n = 0;
    while (!em_vld_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_em_vld"}, em_vld_out, 1);
    for (int i = 0; i <= stall; i++) begin
      checkOutput({tag, "_m"}, em_m_out, m);
      checkOutput({tag, "_m_prev"}, em_m_prev_out, mp);
      checkOutput({tag, "_s"}, em_s_out, s);
      checkOutput({tag, "_o_prev1"}, elem1(em_o_prev_out), op1);
      checkOutput({tag, "_v1"}, elem1(em_v_out), v1);
      checkOutput({tag, "_s_rdy_low"}, s_rdy_out, 0);
      if (i < stall) begin
        @(negedge clk);
        checkOutput({tag, "_em_vld_held"}, em_vld_out, 1);
      end
    end
    em_rdy_in = 1'b1;
    @(negedge clk);
    em_rdy_in = 1'b0;
    em_exp_o_in = eo; em_exp_v_in = ev; em_vld_in = 1'b1;
    checkOutput({tag, "_em_rdy"}, em_rdy_out, 1);
    @(negedge clk);
    em_vld_in = 1'b0;
  endtask

  task automatic takeOutput(input string tag, input logic [ELEM_W-1:0] exp1, input int stall);
    checkOutput({tag, "_o_vld"}, o_vld_out, 1);
    for (int i = 0; i <= stall; i++) begin
      checkOutput({tag, "_o1"}, elem1(o_out), exp1);
      checkOutput({tag, "_o_vld_held"}, o_vld_out, 1);
      checkOutput({tag, "_s_rdy_low"}, s_rdy_out, 0);
      if (i < stall) @(negedge clk);
    end
    o_rdy_in = 1'b1;
    @(negedge clk);
    o_rdy_in = 1'b0;
    checkOutput({tag, "_o_vld_drop"}, o_vld_out, 0);
    checkOutput({tag, "_s_rdy_back"}, s_rdy_out, 1);
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_s_rdy", s_rdy_out, 0);
    checkOutput("rst_em_vld", em_vld_out, 0);
    checkOutput("rst_em_rdy", em_rdy_out, 0);
    checkOutput("rst_o_vld", o_vld_out, 0);
    checkOutput("rst_o1", elem1(o_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_s_rdy", s_rdy_out, 1);

    // Single-key row
    applyStimulus(9'h010, 1'b1, mkVec(27'd131072, 27'd32768));
    checkOutput("single_issue_latency", em_vld_out, 1);
    serveExpmul("single", 9'h010, 9'h010, 9'h010, 27'd0, 27'd32768,
                '0, mkVec(27'd131072, 27'd32768), 0);
    checkOutput("single_o_vld_next", o_vld_out, 1);
    checkOutput("single_o0", o_out[0 +: ELEM_W], 27'd131072);
    takeOutput("single", 27'd32768, 0);

    // Rising max over three keys
    applyStimulus(9'h010, 1'b0, mkVec(27'd1, 27'd100));
    serveExpmul("rise1", 9'h010, 9'h010, 9'h010, 27'd0, 27'd100, '0, mkVec(27'd1, 27'd100), 0);
    checkOutput("rise1_s_rdy_next", s_rdy_out, 1);
    applyStimulus(9'h030, 1'b0, mkVec(27'd1, 27'd200));
    serveExpmul("rise2", 9'h030, 9'h010, 9'h030, 27'd100, 27'd200,
                mkVec(27'd0, 27'd50), mkVec(27'd1, 27'd200), 0);
    applyStimulus(9'h020, 1'b1, mkVec(27'd1, 27'd300));
    serveExpmul("rise3", 9'h030, 9'h030, 9'h020, 27'd250, 27'd300,
                mkVec(27'd0, 27'd250), mkVec(27'd1, 27'd300), 0);
    takeOutput("rise", 27'd550, 0);

    // Negative scores, signed compare
    applyStimulus(9'h100, 1'b0, mkVec(27'd1, 27'd10));
    serveExpmul("neg1", 9'h100, 9'h100, 9'h100, 27'd0, 27'd10, '0, mkVec(27'd1, 27'd10), 0);
    applyStimulus(9'h1F0, 1'b1, mkVec(27'd1, 27'd20));
    serveExpmul("neg2", 9'h1F0, 9'h100, 9'h1F0, 27'd10, 27'd20, '0, mkVec(27'd1, 27'd20), 0);
    takeOutput("neg", 27'd20, 0);

    // Backpressure on both expmul issue and downstream
    applyStimulus(9'h005, 1'b1, mkVec(27'd1, 27'd77));
    serveExpmul("bp", 9'h005, 9'h005, 9'h005, 27'd0, 27'd77, '0, mkVec(27'd1, 27'd77), 5);
    takeOutput("bp", 27'd77, 4);

    // Accumulator overflow
    applyStimulus(9'h001, 1'b1, mkVec(27'd0, 27'd1));
    serveExpmul("ovf", 9'h001, 9'h001, 9'h001, 27'd0, 27'd1,
                mkVec(27'd0, 27'h3FFFFFF), mkVec(27'd0, 27'd1), 0);
`ifdef EXPMUL_ACC_SAT_EN
    checkOutput("ovf_sat_flag", sat_flag_out, 1);
    takeOutput("ovf", 27'h3FFFFFF, 0);
    checkOutput("ovf_sat_clear", sat_flag_out, 0);
`else
    takeOutput("ovf", 27'h4000000, 0);
`endif

    // Reset while waiting for an expmul result
    applyStimulus(9'h040, 1'b0, mkVec(27'd1, 27'd999));
    serveExpmul("rw1", 9'h040, 9'h040, 9'h040, 27'd0, 27'd999, '0, mkVec(27'd1, 27'd999), 0);
    applyStimulus(9'h050, 1'b1, mkVec(27'd1, 27'd5));
    checkOutput("rw2_o_prev1", elem1(em_o_prev_out), 27'd999);
    em_rdy_in = 1'b1;
    @(negedge clk);
    em_rdy_in = 1'b0;
    checkOutput("rw2_in_wait", em_rdy_out, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rw_rst_em_rdy", em_rdy_out, 0);
    checkOutput("rw_rst_s_rdy", s_rdy_out, 0);
    checkOutput("rw_rst_em_vld", em_vld_out, 0);
    checkOutput("rw_rst_o_vld", o_vld_out, 0);
    checkOutput("rw_rst_o1", elem1(o_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(9'h020, 1'b1, mkVec(27'd1, 27'd7));
    serveExpmul("rw3", 9'h020, 9'h020, 9'h020, 27'd0, 27'd7, '0, mkVec(27'd1, 27'd7), 0);
    takeOutput("rw3", 27'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
